gate_op_arbiter: RTL

- Shares one internal 8-op logic-gate unit (NOT/AND/OR/NAND/NOR/XOR/XNOR/BUF) between NREQ requesters.
- Round-robin arbitration with a req/gnt handshake on the request side and a valid/ready handshake on the result side.
- Sits between lab stimulus sources (switch decoders, test sequencers) and the shared gate datapath.
- Sequences one operation at a time: arbitrate, execute, respond.

---
 rtl/gate_op_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin arbiter that shares one 8-op bitwise gate unit
// (NOT/AND/OR/NAND/NOR/XOR/XNOR/BUF) between NREQ requesters, one op at a time.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req          per-requester request, held until its gnt bit pulses
//   op, a, b     per-requester opcode (3 bits) and operands (WIDTH bits)
//   gnt          one-hot, one-cycle pulse when the winner's operands are captured
//   res, res_id  result data and owning requester index
//   res_valid    result available; res_ready accepts it
//   busy         high whenever the sequencer is not idle
//
// Build option: define GATE_ARB_FIXED_PRI_EN for fixed priority (lowest index
// wins, no round-robin pointer). Ports and timing are identical in both builds.
module gate_op_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      res,
  output logic [IDW-1:0]        res_id,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_n;
  logic [2:0]         cap_op, cap_op_n;
  logic [WIDTH-1:0]   cap_a, cap_a_n, cap_b, cap_b_n;
  logic [IDW-1:0]     cap_id, cap_id_n;
  logic [NREQ-1:0]    gnt_n;
  logic [WIDTH-1:0]   res_n;
  logic [IDW-1:0]     res_id_n;
  logic               res_valid_n, busy_n;

  logic [IDW-1:0]     win, cand;
  logic               found;
  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b;

`ifndef GATE_ARB_FIXED_PRI_EN
  logic [IDW-1:0]     ptr, ptr_n;
  logic [IDW:0]       sum;
`endif

  // Bitwise gate function over the full operand width.
  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      3'd0:    r = ~x;
      3'd1:    r = x & y;
      3'd2:    r = x | y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = x ^ y;
      3'd6:    r = ~(x ^ y);
      default: r = x;
    endcase
    return r;
  endfunction

  // Winner search: first set req bit from the search start, wrapping at NREQ-1.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
`ifndef GATE_ARB_FIXED_PRI_EN
    sum   = '0;
`endif
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef GATE_ARB_FIXED_PRI_EN
      cand = IDW'(k);
`else
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
`endif
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_op = op[3*i +: 3];
        sel_a  = a[WIDTH*i +: WIDTH];
        sel_b  = b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    cap_op_n    = cap_op;
    cap_a_n     = cap_a;
    cap_b_n     = cap_b;
    cap_id_n    = cap_id;
    gnt_n       = '0;
    res_n       = res;
    res_id_n    = res_id;
    res_valid_n = res_valid;
`ifndef GATE_ARB_FIXED_PRI_EN
    ptr_n       = ptr;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          cap_op_n   = sel_op;
          cap_a_n    = sel_a;
          cap_b_n    = sel_b;
          cap_id_n   = win;
          gnt_n[win] = 1'b1;
`ifndef GATE_ARB_FIXED_PRI_EN
          ptr_n      = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
`endif
          state_n    = EXEC;
        end
      end
      EXEC: begin
        res_n       = gate_fn(cap_op, cap_a, cap_b);
        res_id_n    = cap_id;
        res_valid_n = 1'b1;
        state_n     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_op    <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_id    <= '0;
      gnt       <= '0;
      res       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
`ifndef GATE_ARB_FIXED_PRI_EN
      ptr       <= '0;
`endif
    end else begin
      state     <= state_n;
      cap_op    <= cap_op_n;
      cap_a     <= cap_a_n;
      cap_b     <= cap_b_n;
      cap_id    <= cap_id_n;
      gnt       <= gnt_n;
      res       <= res_n;
      res_id    <= res_id_n;
      res_valid <= res_valid_n;
      busy      <= busy_n;
`ifndef GATE_ARB_FIXED_PRI_EN
      ptr       <= ptr_n;
`endif
    end
  end

endmodule
